pmem_cache_controller: RTL
==========================

Name: pmem_cache_controller

Overview:
- Read-only program-memory controller with a parametrised direct-mapped instruction cache between the fetchers and external program memory.
- Arbitrates fetcher read requests round-robin and serves hits locally. On a miss, refills a whole multi-word line over one external read channel.
- Supports cache flush (program reload) and exposes hit/miss counters for performance debug.

Parameters:
- ADDR_BITS, 8, program-memory word address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 4, number of fetchers served
- NUM_LINES, 16, cache lines; power of two, >=2
- WORDS_PER_LINE, 2, words per line; power of two, >=2
- COUNTER_BITS, 16, width of hit/miss counters

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  single-cycle pulse; invalidates all lines
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request, held until ready seen
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  request word address
- consumer_read_ready  out  NUM_CONSUMERS  response valid, held until request drops
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS (unpacked)  returned instruction
- mem_read_valid  out  1  external read request
- mem_read_address  out  ADDR_BITS  external word address
- mem_read_ready  in  1  external data valid
- mem_read_data  in  DATA_BITS  external data
- hit_count  out  COUNTER_BITS  saturating lookup-hit count
- miss_count  out  COUNTER_BITS  saturating lookup-miss count

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE) LSBs are the word offset. The next IDX = log2(NUM_LINES) bits are the line index. The remaining bits are the tag. Require ADDR_BITS > OFF+IDX.
- Reset:
  - all outputs 0; all line valid bits 0
  - FSM to IDLE; rr_ptr=0; pending_flush=0
  - reset mid-fill abandons the fill; mem_read_valid=0 the next cycle
- FSM states: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RELAY. Only one request is in service at a time.
- IDLE:
  - If pending_flush or flush: clear all valid bits and pending_flush; no arbitration that cycle.
  - Otherwise select the first consumer c with valid, searching rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS.
  - Latch c and its address; go to LOOKUP. No request: stay.
- LOOKUP:
  - Hit (line valid and tag match):
    - consumer_read_data[c] <= stored word; consumer_read_ready[c] <= 1
    - hit_count++
    - go to RELAY
  - Miss:
    - miss_count++; beat counter k=0; clear line valid bit
    - go to FILL_REQ
- FILL_REQ: mem_read_valid<=1; mem_read_address <= {tag, index, k}; go to FILL_WAIT.
- FILL_WAIT:
  - Hold valid and address until mem_read_ready.
  - On ready: store mem_read_data at word k; mem_read_valid<=0.
  - If k==WORDS_PER_LINE-1: write tag, set valid, go to LOOKUP (re-lookup hits; this hit is counted).
  - Else k++ and go to FILL_REQ. mem_read_valid is low for exactly one cycle between beats.
  - Line always fills from offset 0 upward; the critical word is not fetched first.
- RELAY:
  - Wait for !consumer_read_valid[c].
  - Then consumer_read_ready[c]<=0; rr_ptr <= c+1 (wraps); go to IDLE.
- Latency: request seen in IDLE at cycle t gives ready at t+2 on a hit. On a miss, ready comes after the fill plus LOOKUP.
- Flush:
  - Pulse in IDLE: invalidates at that edge.
  - Pulse in any other state: sets pending_flush. The in-flight fill completes and the consumer is served from the filled line. Invalidation is applied on the next IDLE cycle.
  - Flush coincident with a new request in IDLE: flush wins; the request is arbitrated the next cycle.
- Counters: increment by 1 per LOOKUP outcome; saturate at all-ones (no wrap); cleared only by reset (not by flush).
- consumer_read_data[j] holds its last value when not ready.
- A consumer that re-asserts valid in the cycle after its ready drops is arbitrated behind the other waiting consumers (round-robin fairness).

Test Plan:
- Defaults; memory answers 1 cycle after valid with data = 0xA000|addr. Consumer 0 reads 0x05 -> mem reads 0x04 then 0x05 (valid low 1 cycle between); consumer_read_data[0]=0xA005; miss_count=1, hit_count=1.
- Then consumer 1 reads 0x04 -> no mem_read_valid; ready exactly 2 cycles after valid; data 0xA004; hit_count=2.
- Conflict: read 0x25 (index 2, new tag) -> refill 0x24/0x25, data 0xA025. Next read 0x05 misses again; miss_count increments.
- Round-robin: consumers 0-3 all request 0x10 in the same cycle -> served in order 0,1,2,3. Consumer 0 re-requesting after service is served after 3. Only one refill occurs (miss_count +1, hit_count +4).
- Flush mid-fill: flush pulse during FILL_WAIT of 0x30 -> consumer still gets 0xA030. A following read of 0x31 misses and refetches.
- Reset asserted during FILL_WAIT -> next cycle mem_read_valid=0, all ready=0, counters 0; a subsequent read of a previously cached address misses.

Source files
------------

// File: rtl/pmem_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : pmem_cache_controller
// Description : Read-only program-memory controller with a direct-mapped
//               instruction cache. Fetcher requests are arbitrated
//               round-robin and served one at a time. Hits are answered from
//               the cache. Misses refill a whole line from external memory,
//               one word per beat, starting at offset 0.
//               A flush pulse invalidates every line. A flush that arrives
//               while a request is in service is deferred until the next
//               IDLE cycle. Saturating hit/miss counters support
//               performance debug.
// Ports       :
//   clk, reset             rising-edge clock, synchronous active-high reset
//   flush                  single-cycle pulse, invalidates all lines
//   consumer_read_valid    per-fetcher request, held until ready is seen
//   consumer_read_address  per-fetcher word address (unpacked array)
//   consumer_read_ready    per-fetcher response strobe, held until the
//                          request drops
//   consumer_read_data     per-fetcher instruction word (unpacked array)
//   mem_read_valid/address external read request
//   mem_read_ready/data    external read response
//   hit_count, miss_count  saturating lookup counters
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_cache_controller #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 2,
  parameter int COUNTER_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]    consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]    consumer_read_data [NUM_CONSUMERS],
  output logic                    mem_read_valid,
  output logic [ADDR_BITS-1:0]    mem_read_address,
  input  logic                    mem_read_ready,
  input  logic [DATA_BITS-1:0]    mem_read_data,
  output logic [COUNTER_BITS-1:0] hit_count,
  output logic [COUNTER_BITS-1:0] miss_count
);

  localparam int OFF_BITS   = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS   = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_BITS - OFF_BITS - IDX_BITS;
  localparam int CID_BITS   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int NUM_WORDS  = NUM_LINES * WORDS_PER_LINE;

  localparam logic [OFF_BITS-1:0]     LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);
  localparam logic [CID_BITS-1:0]     LAST_CID  = CID_BITS'(NUM_CONSUMERS - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX   = {COUNTER_BITS{1'b1}};

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_RELAY     = 3'd4;

  generate
    if (ADDR_BITS <= OFF_BITS + IDX_BITS) begin : g_bad_addr_split
      $error("ADDR_BITS must exceed offset plus index width");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]              state_q, state_d;
  logic [CID_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic                    pending_flush_q, pending_flush_d;
  logic [CID_BITS-1:0]     sel_q, sel_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [OFF_BITS-1:0]     beat_q, beat_d;
  logic [NUM_LINES-1:0]    line_valid_q, line_valid_d;
  logic [TAG_BITS-1:0]     line_tag_q  [NUM_LINES];
  logic [TAG_BITS-1:0]     line_tag_d  [NUM_LINES];
  logic [DATA_BITS-1:0]    line_data_q [NUM_WORDS];
  logic [DATA_BITS-1:0]    line_data_d [NUM_WORDS];
  logic [NUM_CONSUMERS-1:0] ready_q, ready_d;
  logic [DATA_BITS-1:0]    rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]    rdata_d [NUM_CONSUMERS];
  logic                    mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
  logic [COUNTER_BITS-1:0] hit_cnt_q, hit_cnt_d;
  logic [COUNTER_BITS-1:0] miss_cnt_q, miss_cnt_d;

  // Fields of the request currently in service.
  logic [OFF_BITS-1:0] lk_off;
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic                flush_now;

  assign lk_off    = addr_q[OFF_BITS-1:0];
  assign lk_idx    = addr_q[OFF_BITS +: IDX_BITS];
  assign lk_tag    = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign lk_hit    = line_valid_q[lk_idx] && (line_tag_q[lk_idx] == lk_tag);
  assign flush_now = pending_flush_q || flush;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_ptr, wrapping.
  // --------------------------------------------------------------------------
  logic                arb_found;
  logic [CID_BITS-1:0] arb_idx;

  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_CONSUMERS) begin
        j = j - NUM_CONSUMERS;
      end
      if (!arb_found && consumer_read_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = CID_BITS'(j);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A flush owns the IDLE cycle; arbitration resumes next cycle.
        if (!flush_now && arb_found) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = lk_hit ? S_RELAY : S_FILL_REQ;
      end
      S_FILL_REQ: begin
        state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_read_ready) begin
          state_d = (beat_q == LAST_BEAT) ? S_LOOKUP : S_FILL_REQ;
        end
      end
      S_RELAY: begin
        if (!consumer_read_valid[sel_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: registered-output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    pending_flush_d = pending_flush_q;
    sel_d           = sel_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    line_valid_d    = line_valid_q;
    line_tag_d      = line_tag_q;
    line_data_d     = line_data_q;
    ready_d         = ready_q;
    rdata_d         = rdata_q;
    mem_valid_d     = mem_valid_q;
    mem_addr_d      = mem_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;

    // Outside IDLE a flush is remembered; the in-flight request finishes
    // against the current contents.
    if (state_q != S_IDLE && flush) begin
      pending_flush_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (flush_now) begin
          line_valid_d    = '0;
          pending_flush_d = 1'b0;
        end else if (arb_found) begin
          sel_d  = arb_idx;
          addr_d = consumer_read_address[arb_idx];
        end
      end
      S_LOOKUP: begin
        if (lk_hit) begin
          rdata_d[sel_q] = line_data_q[{lk_idx, lk_off}];
          ready_d[sel_q] = 1'b1;
          if (hit_cnt_q != CNT_MAX) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end else begin
          if (miss_cnt_q != CNT_MAX) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
          beat_d               = '0;
          // The line is partially overwritten during the fill, so it must
          // not be seen as valid until the last beat lands.
          line_valid_d[lk_idx] = 1'b0;
        end
      end
      S_FILL_REQ: begin
        mem_valid_d = 1'b1;
        mem_addr_d  = {lk_tag, lk_idx, beat_q};
      end
      S_FILL_WAIT: begin
        if (mem_read_ready) begin
          line_data_d[{lk_idx, beat_q}] = mem_read_data;
          mem_valid_d                   = 1'b0;
          if (beat_q == LAST_BEAT) begin
            line_tag_d[lk_idx]   = lk_tag;
            line_valid_d[lk_idx] = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RELAY: begin
        if (!consumer_read_valid[sel_q]) begin
          ready_d[sel_q] = 1'b0;
          rr_ptr_d       = (sel_q == LAST_CID) ? '0 : sel_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      pending_flush_q <= 1'b0;
      sel_q           <= '0;
      addr_q          <= '0;
      beat_q          <= '0;
      line_valid_q    <= '0;
      ready_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_addr_q      <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      pending_flush_q <= pending_flush_d;
      sel_q           <= sel_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      line_valid_q    <= line_valid_d;
      ready_q         <= ready_d;
      mem_valid_q     <= mem_valid_d;
      mem_addr_q      <= mem_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      rdata_q         <= rdata_d;
    end
  end

  // Tag and data storage are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    line_tag_q  <= line_tag_d;
    line_data_q <= line_data_d;
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = rdata_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign hit_count           = hit_cnt_q;
  assign miss_count          = miss_cnt_q;

endmodule
`default_nettype wire
